// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter, processor and data RAM.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  // Only reads expect a response; writes retire at the RAM edge.
  function automatic owner_e rsp_owner_of(input logic cpu_gnt, input logic cpu_we,
                                          input logic aux_gnt, input logic aux_we);
    if (cpu_gnt && !cpu_we)      return OWN_CPU;
    else if (aux_gnt && !aux_we) return OWN_AUX;
    else                         return OWN_NONE;
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Aux grant decision plus the saturating starvation counter that bounds aux waiting.
module dmem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       aux_req,
  output logic       aux_gnt,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  // Aux wins when the CPU is idle or once aux has been refused CNT_MAX times in a row.
  assign aux_gnt = aux_req & (~cpu_req | (starve_cnt == CNT_MAX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (aux_req && !aux_gnt) begin
      if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU priority, bounded aux starvation,
// one-cycle read responses steered back to the issuing master.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  logic [3:0] starve_cnt;
  owner_e     rsp_owner;

  dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .aux_req    (aux_req),
    .aux_gnt    (aux_gnt),
    .starve_cnt (starve_cnt)
  );

  assign cpu_gnt = cpu_req & ~aux_gnt;

  // Idle bus drives zeros so the RAM never sees a stale address or a spurious write.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (cpu_gnt) begin
      ram_wEn    = cpu_we;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_wdata;
    end else if (aux_gnt) begin
      ram_wEn    = aux_we;
      ram_addr   = aux_addr;
      ram_dataIn = aux_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rsp_owner <= OWN_NONE;
    else        rsp_owner <= rsp_owner_of(cpu_gnt, cpu_we, aux_gnt, aux_we);
  end

  assign cpu_rvalid = (rsp_owner == OWN_CPU);
  assign aux_rvalid = (rsp_owner == OWN_AUX);
  assign cpu_rdata  = cpu_rvalid ? ram_dataOut : '0;
  assign aux_rdata  = aux_rvalid ? ram_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0;
  logic [AW-1:0] cpu_addr = '0, aux_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, aux_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, ram_wEn;
  logic [DW-1:0] cpu_rdata, aux_rdata, ram_dataIn;
  logic [DW-1:0] ram_dataOut = '0;
  logic [AW-1:0] ram_addr;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cpu_rv_cyc = -1, aux_rv_cyc = -1;
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] aux_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the expected read data whenever a master sees rvalid.
  always @(negedge clock) begin
    if (cpu_rvalid) begin
      cpu_rv_cyc = cyc;
      if (cpu_q.size() == 0) chk("cpu_unexpected_rvalid", 32'd1, 32'd0);
      else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end else if (cpu_rdata !== '0) chk("cpu_rdata_idle", cpu_rdata, '0);
    if (aux_rvalid) begin
      aux_rv_cyc = cyc;
      if (aux_q.size() == 0) chk("aux_unexpected_rvalid", 32'd1, 32'd0);
      else chk("aux_rdata", aux_rdata, aux_q.pop_front());
    end else if (aux_rdata !== '0) chk("aux_rdata_idle", aux_rdata, '0);
  end

  // Requester protocol: a refused request must be held unchanged.
  logic          cp_pend = 0, ap_pend = 0;
  logic [44:0]   cp_fields, ap_fields;
  always @(negedge clock) begin
    if (!reset) begin
      cp_pend = 0; ap_pend = 0;
    end else begin
      if (cp_pend) chk("cpu_req_held", {12'd0, cpu_req, cpu_we, cpu_addr, cpu_wdata}, {12'd0, cp_fields});
      if (ap_pend) chk("aux_req_held", {12'd0, aux_req, aux_we, aux_addr, aux_wdata}, {12'd0, ap_fields});
      cp_pend = cpu_req & ~cpu_gnt;
      ap_pend = aux_req & ~aux_gnt;
      cp_fields = {cpu_req, cpu_we, cpu_addr, cpu_wdata};
      ap_fields = {aux_req, aux_we, aux_addr, aux_wdata};
    end
  end

  // Issue one transfer on master m (0 cpu, 1 aux); call at posedge+1, returns at posedge+1.
  task automatic op(input bit m, input bit we, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] exp, output int waited);
    logic g;
    waited = 0;
    if (m) begin aux_req = 1; aux_we = we; aux_addr = a; aux_wdata = d; end
    else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    @(negedge clock);
    g = m ? aux_gnt : cpu_gnt;
    while (!g && waited < 20) begin
      @(negedge clock);
      waited++;
      g = m ? aux_gnt : cpu_gnt;
    end
    if (!g) chk("grant_timeout", 32'd0, 32'd1);
    else if (!we) begin
      if (m) aux_q.push_back(exp); else cpu_q.push_back(exp);
    end
    @(posedge clock); #1;
    if (m) aux_req = 0; else cpu_req = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w;
  string pat;
  initial begin
    // 1: reset then idle
    repeat (2) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    chk("rst_gnt", {cpu_gnt, aux_gnt}, 0);
    chk("rst_rvalid", {cpu_rvalid, aux_rvalid}, 0);
    chk("rst_wen", ram_wEn, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_dataIn, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    @(posedge clock); #1;

    // 2: CPU write then read
    op(0, 1, 12'h010, 32'hDEADBEEF, 0, w);
    chk("cpu_wr_wait", w, 0);
    op(0, 0, 12'h010, 0, 32'hDEADBEEF, w);
    chk("cpu_rd_wait", w, 0);
    @(posedge clock); #1;

    // 3: both held for 12 cycles
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h100; cpu_wdata = 32'h1;
    aux_req = 1; aux_we = 1; aux_addr = 12'h200; aux_wdata = 32'h2;
    pat = "CCCCACCCCACC";
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk($sformatf("arb_pat%0d", i), {cpu_gnt, aux_gnt},
          (pat[i] == "A") ? 2'b01 : 2'b10);
    end
    @(posedge clock); #1;
    cpu_req = 0; aux_req = 0;
    @(posedge clock); #1;

    // 4: alternating back-to-back reads
    op(0, 1, 12'h001, 32'h11, 0, w);
    op(1, 1, 12'h002, 32'h22, 0, w);
    op(0, 0, 12'h001, 0, 32'h11, w);
    op(1, 0, 12'h002, 0, 32'h22, w);
    chk("alt_aux_wait", w, 0);
    repeat (2) @(negedge clock);
    chk("alt_no_bubble", aux_rv_cyc - cpu_rv_cyc, 1);
    @(posedge clock); #1;

    // 5: aux read granted, reset before its response
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h300; cpu_wdata = 32'h3;
    aux_req = 1; aux_we = 0; aux_addr = 12'h002; aux_wdata = 0;
    repeat (2) begin @(negedge clock); chk("rst5_cpu_first", {cpu_gnt, aux_gnt}, 2'b10); end
    @(posedge clock); #1 cpu_req = 0;
    @(negedge clock);
    chk("rst5_aux_gnt", aux_gnt, 1);
    chk("rst5_starve_pre", dut.starve_cnt, 2);
    #1 reset = 0; aux_req = 0;
    @(negedge clock);
    chk("rst5_rvalid_in_rst", {cpu_rvalid, aux_rvalid}, 0);
    @(posedge clock); #1 reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst5_no_aux_rvalid", aux_rvalid, 0);
    end
    chk("rst5_starve", dut.starve_cnt, 0);
    @(posedge clock); #1;

    // 6: aux write contends with CPU request
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010; cpu_wdata = 0;
    aux_req = 1; aux_we = 1; aux_addr = 12'h020; aux_wdata = 32'h5;
    @(negedge clock);
    chk("c6_cpu_wins", {cpu_gnt, aux_gnt}, 2'b10);
    cpu_q.push_back(32'hDEADBEEF);
    @(posedge clock); #1 cpu_req = 0;
    @(negedge clock);
    chk("c6_aux_next", {cpu_gnt, aux_gnt}, 2'b01);
    @(posedge clock); #1 aux_req = 0;
    op(0, 0, 12'h020, 0, 32'h5, w);
    op(1, 0, 12'h020, 0, 32'h5, w);

    repeat (3) @(negedge clock);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("aux_q_drained", aux_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
